// File: rtl/sn_popcount_seq.sv
// ---------------------------------------------------------------------------
// sn_popcount_seq
//
// Sequential population counter. An accepted W-bit word is counted seven bits
// per cycle by a single shared seven-input bit sorter. The sorter turns each
// chunk into a thermometer code, which is converted to a 3-bit count and
// added into an accumulator. The result is offered on a valid/ready output.
//
// Optional feature macro: SN_POPCOUNT_ZSKIP_EN
//   When defined, the RUN phase ends early once every chunk still waiting in
//   the shift register is zero. The count is the same either way; only the
//   latency changes.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : requester presents in_data
//   in_ready   : block can accept a word (IDLE only)
//   in_data    : W-bit word to be counted
//   out_valid  : out_count holds a finished result (DONE only)
//   out_ready  : consumer accepts the result
//   out_count  : number of ones in the accepted word, zero when not valid
//   busy       : high while counting or holding a result
// ---------------------------------------------------------------------------

// Seven-input bit sorter. Uses odd-even transposition, so every ones bit
// moves toward index 0. The result is a thermometer code: k ones in the input
// give sorted[k-1:0] set and every other bit clear.
module seven_sorter (
    input  logic [6:0] unsorted,
    output logic [6:0] sorted
);

    logic [6:0] stage;
    logic       hi;
    logic       lo;

    // A compare-exchange on single bits is OR (larger) and AND (smaller).
    // Seven alternating rounds fully sort seven elements.
    always_comb begin
        stage = unsorted;
        hi    = 1'b0;
        lo    = 1'b0;
        for (int r = 0; r < 7; r++) begin
            for (int i = r % 2; i < 6; i += 2) begin
                hi           = stage[i] | stage[i+1];
                lo           = stage[i] & stage[i+1];
                stage[i]     = hi;
                stage[i+1]   = lo;
            end
        end
        sorted = stage;
    end

endmodule

module sn_popcount_seq #(
    parameter  int NCHUNK = 4,
    localparam int W      = 7 * NCHUNK,
    localparam int CNT_W  = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       shreg;
    logic [CNT_W-1:0]   acc;
    logic [IDX_W-1:0]   idx;
    logic [6:0]         therm;
    logic [2:0]         chunk_count;
    logic               last_chunk;

    // The current chunk always sits in the low seven bits of the shift
    // register, so the sorter input never needs a multiplexer.
    seven_sorter u_sorter (
        .unsorted (shreg[6:0]),
        .sorted   (therm)
    );

    // Thermometer to binary. Each count bit is set by the "edges" of the
    // thermometer code where that bit of the binary value is one.
    assign chunk_count[2] = therm[3];
    assign chunk_count[1] = (therm[1] & ~therm[3]) | therm[5];
    assign chunk_count[0] = (therm[0] & ~therm[1]) | (therm[2] & ~therm[3])
                          | (therm[4] & ~therm[5]) | therm[6];

`ifdef SN_POPCOUNT_ZSKIP_EN
    // The chunk in flight is the last one worth counting when everything
    // above it is already zero.
    assign last_chunk = (idx == IDX_W'(NCHUNK - 1)) || ((shreg >> 7) == '0);
`else
    assign last_chunk = (idx == IDX_W'(NCHUNK - 1));
`endif

    // Next-state and output decode. Outputs depend only on the state, so
    // out_count is forced to zero outside DONE and cannot glitch with input
    // activity.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_count  = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_count = acc;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and datapath. A word is loaded on the input handshake,
    // and each RUN cycle adds one chunk's count and moves the next chunk
    // down. The accumulator cannot overflow because CNT_W holds W.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc + CNT_W'(chunk_count);
                    shreg <= shreg >> 7;
                    idx   <= idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn_popcount_seq.sv
// ---------------------------------------------------------------------------
// tb_sn_popcount_seq
//
// Scoreboard bench for sn_popcount_seq with NCHUNK=4. When a word is accepted,
// the expected count and the cycle in which the result should first appear
// are queued. A separate monitor pops an entry when a result is presented and
// checks the value, first-valid cycle, and stability under backpressure.
// Follows SN_POPCOUNT_ZSKIP_EN for the expected latency.
// ---------------------------------------------------------------------------
module tb_sn_popcount_seq;

    localparam int NCHUNK = 4;
    localparam int W      = 7 * NCHUNK;
    localparam int CNT_W  = $clog2(W + 1);
`ifdef SN_POPCOUNT_ZSKIP_EN
    localparam bit ZSKIP  = 1'b1;
`else
    localparam bit ZSKIP  = 1'b0;
`endif

    typedef struct {
        int cnt;
        int due;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    int   checks;
    int   errors;
    int   cyc;
    int   n_accepts;
    int   last_accept;
    int   last_hs;
    bit   presenting;
    exp_t cur;
    exp_t sb[$];

    sn_popcount_seq #(.NCHUNK(NCHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter. The monitors read it on the falling edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Global watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one value against its expectation and update the counters.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Number of RUN cycles for a word: every chunk without the zero skip,
    // otherwise up to the highest nonzero chunk, with a minimum of one.
    function automatic int run_cycles(input logic [W-1:0] w);
        int k;
        logic [W-1:0] t;
        k = 1;
        for (int c = 0; c < NCHUNK; c++) begin
            t = w >> (7 * c);
            if (t[6:0] != 7'd0) k = c + 1;
        end
        return ZSKIP ? k : NCHUNK;
    endfunction

    // Acceptance tracker. An input handshake seen here completes at the next
    // rising edge, which is when the expected result is queued.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back('{cnt: $countones(in_data), due: cyc + run_cycles(in_data) + 1});
            last_accept = cyc;
            n_accepts++;
        end
    end

    // Output monitor. Each new result pops the scoreboard, and its value is
    // checked every cycle it stays valid. While no result is valid,
    // out_count must be zero.
    always @(negedge clk) begin
        if (rst) begin
            presenting = 1'b0;
        end else if (!out_valid) begin
            checkOutput("idle_count_zero", int'(out_count), 0);
            presenting = 1'b0;
        end else begin
            if (!presenting) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                    cur = '{cnt: -1, due: -1};
                end else begin
                    cur = sb.pop_front();
                    checkOutput("first_valid_cycle", cyc, cur.due);
                end
                presenting = 1'b1;
            end
            if (cur.cnt >= 0) checkOutput("out_count", int'(out_count), cur.cnt);
            checkOutput("in_ready_in_done", int'(in_ready), 0);
            checkOutput("busy_in_done", int'(busy), 1);
            if (out_ready) begin
                presenting = 1'b0;
                last_hs    = cyc;
            end
        end
    end

    // Offer one word and hold it until it is taken. Called and returns just
    // after a rising edge. With rnd set, out_ready is randomized while
    // waiting.
    task automatic applyStimulus(input logic [W-1:0] w, input bit rnd);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_wait", 0, 1);
        end else begin
            in_valid = 1'b1;
            in_data  = w;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // Wait with a bound for a result to be presented.
    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("wait_valid", int'(out_valid), 1);
    endtask

    // Wait with a bound for every queued result to be consumed.
    task automatic wait_drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || presenting || busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_empty", sb.size(), 0);
    endtask

    // Directed cases first, then a randomized run.
    initial begin
        int base;
        int n;
        logic [W-1:0] w;
        logic [W-1:0] directed [4];

        checks = 0; errors = 0; cyc = 0; n_accepts = 0;
        last_accept = -1; last_hs = -1; presenting = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_count", int'(out_count), 0);
        checkOutput("reset_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All ones, then in_ready must return one cycle after the result.
        applyStimulus(28'hFFFFFFF, 1'b0);
        wait_valid();
        @(posedge clk); #1;
        checkOutput("in_ready_after_done", int'(in_ready), 1);
        wait_drain();

        // Alternating pattern, zero, lowest bit only, highest bit only.
        directed[0] = 28'h5555555;
        directed[1] = 28'h0000000;
        directed[2] = 28'h0000001;
        directed[3] = 28'h8000000;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(directed[i], 1'b0);
            wait_drain();
        end

        // Reset during RUN discards the word.
        applyStimulus(28'hFFFFFFF, 1'b0);
        checkOutput("run_busy", int'(busy), 1);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        checkOutput("midrun_reset_in_ready", int'(in_ready), 1);
        checkOutput("midrun_reset_out_valid", int'(out_valid), 0);
        checkOutput("midrun_reset_out_count", int'(out_count), 0);
        checkOutput("midrun_reset_busy", int'(busy), 0);
        @(posedge clk); #1;
        checkOutput("midrun_reset_queue", sb.size(), 0);

        // Backpressure: the result holds while a new word waits.
        out_ready = 1'b0;
        applyStimulus(28'h1234567, 1'b0);
        wait_valid();
        base = n_accepts;
        in_valid = 1'b1;
        in_data  = 28'h0F0F0F0;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("bp_in_ready", int'(in_ready), 0);
            checkOutput("bp_no_accept", n_accepts, base);
        end
        out_ready = 1'b1;
        n = 0;
        while (n_accepts == base && n < 20) begin @(posedge clk); #1; n++; end
        in_valid = 1'b0;
        checkOutput("bp_accept_after_hs", last_accept, last_hs + 1);
        wait_drain();

        // Back-to-back with in_valid held high.
        base = n_accepts;
        in_valid = 1'b1;
        in_data  = 28'h000007F;
        @(posedge clk); #1;
        in_data  = 28'h0003F80;
        n = 0;
        while (n_accepts < base + 2 && n < 40) begin @(posedge clk); #1; n++; end
        in_valid = 1'b0;
        checkOutput("b2b_accepts", n_accepts, base + 2);
        checkOutput("b2b_second_accept", last_accept, last_hs + 1);
        wait_drain();

        // Randomized words, with chunks often zeroed, and random backpressure.
        for (int i = 0; i < 40; i++) begin
            w = W'($urandom);
            for (int c = 0; c < NCHUNK; c++) begin
                if ($urandom_range(0, 2) == 0) w &= ~(W'(7'h7F) << (7 * c));
            end
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            applyStimulus(w, 1'b1);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
